// File: rtl/tdm_demux_rx.sv
// TDM receive demultiplexer: locks onto the start-of-frame marker and steers
// each accepted sample into its per-channel register with a one-cycle strobe.

module tdm_demux_ch #(
   parameter int WIDTH = 8
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             wr,
   input  logic [WIDTH-1:0] d,
   output logic [WIDTH-1:0] q,
   output logic             stb
);
   always_ff @(posedge clk) begin
      if (rst) begin
         q   <= '0;
         stb <= 1'b0;
      end else begin
         stb <= wr;
         if (wr) q <= d;
      end
   end
endmodule

module tdm_demux_rx #(
   parameter int WIDTH = 8,
   parameter int NCH   = 4
) (
   input  logic               clk,
   input  logic               rst,
   input  logic [WIDTH-1:0]   din,
   input  logic               din_valid,
   input  logic               sof,
   output logic [NCH*WIDTH-1:0] ch_data,
   output logic [NCH-1:0]     ch_valid,
   output logic               frame_done,
   output logic               sync_err,
   output logic               locked
);
   localparam int SW = (NCH > 1) ? $clog2(NCH) : 1;
   localparam logic [SW-1:0] LAST = SW'(NCH - 1);

   typedef enum logic {HUNT = 1'b0, LOCKED = 1'b1} state_t;

   state_t          state;
   logic [SW-1:0]   slot;
   logic [NCH-1:0]  wr_sel;

   // Any qualified sof lands in channel 0 (relock or early-sof recovery);
   // plain samples only land while locked and mid-frame.
   always_comb begin
      wr_sel = '0;
      if (din_valid) begin
         if (sof)
            wr_sel[0] = 1'b1;
         else if (state == LOCKED && slot != '0)
            for (int k = 1; k < NCH; k++)
               if (slot == SW'(k)) wr_sel[k] = 1'b1;
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state      <= HUNT;
         slot       <= '0;
         frame_done <= 1'b0;
         sync_err   <= 1'b0;
         locked     <= 1'b0;
      end else begin
         frame_done <= 1'b0;
         sync_err   <= 1'b0;
         if (din_valid) begin
            case (state)
               HUNT: begin
                  if (sof) begin
                     state  <= LOCKED;
                     locked <= 1'b1;
                     slot   <= SW'(1);
                  end
               end
               LOCKED: begin
                  if (sof) begin
                     sync_err <= (slot != '0);
                     slot     <= SW'(1);
                  end else if (slot == '0) begin
                     sync_err <= 1'b1;
                     state    <= HUNT;
                     locked   <= 1'b0;
                  end else if (slot == LAST) begin
                     frame_done <= 1'b1;
                     slot       <= '0;
                  end else begin
                     slot <= slot + SW'(1);
                  end
               end
               default: begin
                  state  <= HUNT;
                  locked <= 1'b0;
                  slot   <= '0;
               end
            endcase
         end
      end
   end

   for (genvar k = 0; k < NCH; k++) begin : g_ch
      tdm_demux_ch #(.WIDTH(WIDTH)) u_ch (
         .clk (clk),
         .rst (rst),
         .wr  (wr_sel[k]),
         .d   (din),
         .q   (ch_data[k*WIDTH +: WIDTH]),
         .stb (ch_valid[k])
      );
   end
endmodule
